// File: rtl/dram_req_pkg.sv
// Shared widths and queue entry types for the sctag->DRAM request receiver.
// Optional DRAM_REQ_ADDR_PAR_EN adds a poison bit to both entry types.
package dram_req_pkg;

    localparam int ADDR_W = 35;
    localparam int ID_W   = 3;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [ID_W-1:0]   id;
        logic              dummy;
`ifdef DRAM_REQ_ADDR_PAR_EN
        logic              poison;
`endif
    } rd_entry_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
`ifdef DRAM_REQ_ADDR_PAR_EN
        logic              poison;
`endif
    } wr_entry_t;

endpackage

// File: rtl/dram_req_fifo.sv
// Synchronous FIFO of a generic entry type; power-of-2 depth, head shown
// combinationally, push on a full FIFO is accepted when a pop happens in the same cycle.
module dram_req_fifo #(
    parameter int  DEPTH   = 8,
    parameter type entry_t = logic
) (
    input  logic                     rclk,
    input  logic                     rst_l,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    output entry_t                   head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               push_ok, pop_ok;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign head    = mem_q[rd_ptr_q];
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge rclk) begin
        if (!rst_l) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // NOTE: storage is not reset; the count alone defines which entries are valid.
    always_ff @(posedge rclk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/dram_sctag_req_rcv.sv
// sctag->DRAM request receiver: holding stage, read/write queues, acks, arbitrated command port.
// Optional DRAM_REQ_ADDR_PAR_EN adds address parity checking with poisoned entries.
module dram_sctag_req_rcv
    import dram_req_pkg::*;
#(
    parameter int RD_DEPTH = 8,
    parameter int WR_DEPTH = 8,
    parameter int WR_HI_WM = 6
) (
    input  logic                        rclk,
    input  logic                        rst_l,
    input  logic                        sctag_dram_rd_req,
    input  logic                        sctag_dram_rd_dummy_req,
    input  logic [2:0]                  sctag_dram_rd_req_id,
    input  logic                        sctag_dram_wr_req,
    input  logic [34:0]                 sctag_dram_addr,
    output logic                        dram_sctag_rd_ack,
    output logic                        dram_sctag_wr_ack,
    output logic                        cmd_vld,
    output logic                        cmd_is_wr,
    output logic [34:0]                 cmd_addr,
    output logic [2:0]                  cmd_id,
    output logic                        cmd_dummy,
    input  logic                        cmd_pop,
    output logic [$clog2(RD_DEPTH):0]   rd_q_cnt,
    output logic [$clog2(WR_DEPTH):0]   wr_q_cnt,
    output logic                        proto_err
`ifdef DRAM_REQ_ADDR_PAR_EN
    ,
    input  logic                        sctag_dram_addr_par,
    output logic                        addr_par_err
`endif
);

    localparam int RD_CW = $clog2(RD_DEPTH) + 1;
    localparam int WR_CW = $clog2(WR_DEPTH) + 1;

    rd_entry_t  rd_in, rd_hold_q, rd_hold_d, rd_cur, rd_head;
    wr_entry_t  wr_in, wr_hold_q, wr_hold_d, wr_cur, wr_head;
    logic       rd_hold_vld_q, rd_hold_vld_d, wr_hold_vld_q, wr_hold_vld_d;
    logic       rd_ack_q, rd_ack_d, wr_ack_q, wr_ack_d;
    logic       proto_err_q, proto_err_d, sel_wr_q, sel_wr_d;
    logic       rd_load, wr_load, rd_cur_vld, wr_cur_vld;
    logic       rd_push, wr_push, rd_pop, wr_pop;
    logic       rd_full, rd_empty, wr_full, wr_empty, wr_drop;
    logic [RD_CW-1:0] rd_cnt_nx;
    logic [WR_CW-1:0] wr_cnt_nx;

    // A request arriving while its holding register is busy is dropped; on a collision the read wins.
    assign rd_load = sctag_dram_rd_req & ~rd_hold_vld_q;
    assign wr_load = sctag_dram_wr_req & ~sctag_dram_rd_req & ~wr_hold_vld_q;

`ifdef DRAM_REQ_ADDR_PAR_EN
    logic par_bad, addr_par_err_q, addr_par_err_d;
    assign par_bad        = (^sctag_dram_addr) != sctag_dram_addr_par;
    assign addr_par_err_d = addr_par_err_q | (par_bad & (rd_load | wr_load));
    assign addr_par_err   = addr_par_err_q;
    // Poisoned writes are silently discarded at the head instead of being presented.
    assign wr_drop        = sel_wr_q & ~wr_empty & wr_head.poison;
`else
    assign wr_drop        = 1'b0;
`endif

    always_comb begin
        rd_in       = '0;
        rd_in.addr  = sctag_dram_addr;
        rd_in.id    = sctag_dram_rd_req_id;
        rd_in.dummy = sctag_dram_rd_dummy_req;
        wr_in       = '0;
        wr_in.addr  = {sctag_dram_addr[34:1], 1'b0};
`ifdef DRAM_REQ_ADDR_PAR_EN
        rd_in.poison = par_bad;
        wr_in.poison = par_bad;
`endif
    end

    // The incoming request bypasses the holding register so it can enqueue in the cycle it arrives.
    assign rd_cur_vld = rd_hold_vld_q | rd_load;
    assign wr_cur_vld = wr_hold_vld_q | wr_load;
    assign rd_cur     = rd_hold_vld_q ? rd_hold_q : rd_in;
    assign wr_cur     = wr_hold_vld_q ? wr_hold_q : wr_in;

    assign cmd_vld = sel_wr_q ? (~wr_empty & ~wr_drop) : ~rd_empty;
    assign rd_pop  = cmd_pop & cmd_vld & ~sel_wr_q;
    assign wr_pop  = (cmd_pop & cmd_vld & sel_wr_q) | wr_drop;
    assign rd_push = rd_cur_vld & (~rd_full | rd_pop);
    assign wr_push = wr_cur_vld & (~wr_full | wr_pop);

    assign rd_cnt_nx = rd_q_cnt + RD_CW'(rd_push) - RD_CW'(rd_pop);
    assign wr_cnt_nx = wr_q_cnt + WR_CW'(wr_push) - WR_CW'(wr_pop);

    always_comb begin
        rd_hold_d     = rd_cur;
        wr_hold_d     = wr_cur;
        rd_hold_vld_d = rd_cur_vld & ~rd_push;
        wr_hold_vld_d = wr_cur_vld & ~wr_push;
        rd_ack_d      = rd_push;
        wr_ack_d      = wr_push;
        proto_err_d   = proto_err_q
                      | (sctag_dram_rd_req & sctag_dram_wr_req)
                      | (sctag_dram_rd_req & rd_hold_vld_q)
                      | (sctag_dram_wr_req & wr_hold_vld_q)
                      | (cmd_pop & ~cmd_vld);
        // Selection looks at post-update occupancy so it matches what the next cycle presents.
        sel_wr_d = sel_wr_q;
        if (!cmd_vld || cmd_pop) begin
            if (wr_cnt_nx >= WR_CW'(WR_HI_WM)) sel_wr_d = 1'b1;
            else if (rd_cnt_nx != '0)         sel_wr_d = 1'b0;
            else if (wr_cnt_nx != '0)         sel_wr_d = 1'b1;
        end
    end

    always_ff @(posedge rclk) begin
        if (!rst_l) begin
            rd_hold_q     <= '0;
            wr_hold_q     <= '0;
            rd_hold_vld_q <= 1'b0;
            wr_hold_vld_q <= 1'b0;
            rd_ack_q      <= 1'b0;
            wr_ack_q      <= 1'b0;
            proto_err_q   <= 1'b0;
            sel_wr_q      <= 1'b0;
        end else begin
            rd_hold_q     <= rd_hold_d;
            wr_hold_q     <= wr_hold_d;
            rd_hold_vld_q <= rd_hold_vld_d;
            wr_hold_vld_q <= wr_hold_vld_d;
            rd_ack_q      <= rd_ack_d;
            wr_ack_q      <= wr_ack_d;
            proto_err_q   <= proto_err_d;
            sel_wr_q      <= sel_wr_d;
        end
    end

`ifdef DRAM_REQ_ADDR_PAR_EN
    always_ff @(posedge rclk) begin
        if (!rst_l) addr_par_err_q <= 1'b0;
        else        addr_par_err_q <= addr_par_err_d;
    end
`endif

    dram_req_fifo #(.DEPTH(RD_DEPTH), .entry_t(rd_entry_t)) u_rd_fifo (
        .rclk      (rclk),
        .rst_l     (rst_l),
        .push      (rd_push),
        .push_data (rd_cur),
        .pop       (rd_pop),
        .head      (rd_head),
        .full      (rd_full),
        .empty     (rd_empty),
        .count     (rd_q_cnt)
    );

    dram_req_fifo #(.DEPTH(WR_DEPTH), .entry_t(wr_entry_t)) u_wr_fifo (
        .rclk      (rclk),
        .rst_l     (rst_l),
        .push      (wr_push),
        .push_data (wr_cur),
        .pop       (wr_pop),
        .head      (wr_head),
        .full      (wr_full),
        .empty     (wr_empty),
        .count     (wr_q_cnt)
    );

    assign dram_sctag_rd_ack = rd_ack_q;
    assign dram_sctag_wr_ack = wr_ack_q;
    assign proto_err         = proto_err_q;
    assign cmd_is_wr         = sel_wr_q;
    assign cmd_addr          = sel_wr_q ? wr_head.addr : rd_head.addr;
    assign cmd_id            = sel_wr_q ? 3'd0 : rd_head.id;
`ifdef DRAM_REQ_ADDR_PAR_EN
    assign cmd_dummy         = ~sel_wr_q & (rd_head.dummy | rd_head.poison);
`else
    assign cmd_dummy         = ~sel_wr_q & rd_head.dummy;
`endif

endmodule

// File: tb/tb_dram_sctag_req_rcv.sv
// Directed bench for dram_sctag_req_rcv (default build, parity feature off).
module tb_dram_sctag_req_rcv;

    logic        rclk = 1'b0;
    logic        rst_l;
    logic        rd_req, rd_dummy, wr_req, cmd_pop;
    logic [2:0]  rd_id;
    logic [34:0] addr;
    logic        rd_ack, wr_ack, cmd_vld, cmd_is_wr, cmd_dummy, proto_err;
    logic [34:0] cmd_addr;
    logic [2:0]  cmd_id;
    logic [3:0]  rd_q_cnt, wr_q_cnt;

    int total = 0;
    int bad   = 0;

    always #5 rclk = ~rclk;

    dram_sctag_req_rcv dut (
        .rclk                    (rclk),
        .rst_l                   (rst_l),
        .sctag_dram_rd_req       (rd_req),
        .sctag_dram_rd_dummy_req (rd_dummy),
        .sctag_dram_rd_req_id    (rd_id),
        .sctag_dram_wr_req       (wr_req),
        .sctag_dram_addr         (addr),
        .dram_sctag_rd_ack       (rd_ack),
        .dram_sctag_wr_ack       (wr_ack),
        .cmd_vld                 (cmd_vld),
        .cmd_is_wr               (cmd_is_wr),
        .cmd_addr                (cmd_addr),
        .cmd_id                  (cmd_id),
        .cmd_dummy               (cmd_dummy),
        .cmd_pop                 (cmd_pop),
        .rd_q_cnt                (rd_q_cnt),
        .wr_q_cnt                (wr_q_cnt),
        .proto_err               (proto_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic send_rd(input logic [34:0] a, input logic [2:0] id, input logic dmy);
        rd_req = 1'b1; addr = a; rd_id = id; rd_dummy = dmy;
        tick();
        rd_req = 1'b0; rd_dummy = 1'b0;
    endtask

    task automatic send_wr(input logic [34:0] a);
        wr_req = 1'b1; addr = a;
        tick();
        wr_req = 1'b0;
    endtask

    task automatic do_pop();
        cmd_pop = 1'b1;
        tick();
        cmd_pop = 1'b0;
    endtask

    initial begin
        rst_l = 1'b0; rd_req = 1'b0; rd_dummy = 1'b0; wr_req = 1'b0;
        cmd_pop = 1'b0; rd_id = 3'd0; addr = '0;
        tick(); tick();
        check("rst_rd_cnt", rd_q_cnt, 0);
        check("rst_wr_cnt", wr_q_cnt, 0);
        check("rst_cmd_vld", cmd_vld, 0);
        check("rst_acks", {rd_ack, wr_ack}, 0);
        check("rst_proto_err", proto_err, 0);
        rst_l = 1'b1;
        tick();

        // Single read
        send_rd(35'h1_2345_6789, 3'd3, 1'b0);
        check("rd1_ack", rd_ack, 1);
        check("rd1_no_wr_ack", wr_ack, 0);
        check("rd1_cmd_vld", cmd_vld, 1);
        check("rd1_is_wr", cmd_is_wr, 0);
        check("rd1_addr", cmd_addr, 35'h1_2345_6789);
        check("rd1_id", cmd_id, 3);
        check("rd1_dummy", cmd_dummy, 0);
        check("rd1_cnt", rd_q_cnt, 1);
        tick();
        check("rd1_ack_pulse", rd_ack, 0);
        do_pop();
        check("rd1_pop_vld", cmd_vld, 0);
        check("rd1_pop_cnt", rd_q_cnt, 0);
        check("rd1_no_err", proto_err, 0);

        // Single write, bit 5 forced low
        send_wr(35'h0_0000_0021);
        check("wr1_ack", wr_ack, 1);
        check("wr1_no_rd_ack", rd_ack, 0);
        check("wr1_cmd_vld", cmd_vld, 1);
        check("wr1_is_wr", cmd_is_wr, 1);
        check("wr1_addr", cmd_addr, 35'h0_0000_0020);
        check("wr1_id", cmd_id, 0);
        check("wr1_cnt", wr_q_cnt, 1);
        do_pop();
        check("wr1_pop_cnt", wr_q_cnt, 0);
        check("wr1_pop_vld", cmd_vld, 0);

        // Fill read queue, 9th read held until a pop frees an entry
        for (int i = 0; i < 8; i++) begin
            send_rd(35'h100 + 35'(i), 3'(i), i == 5);
            check($sformatf("fill_ack%0d", i), rd_ack, 1);
        end
        check("full_cnt", rd_q_cnt, 8);
        check("full_head", cmd_addr, 35'h100);
        send_rd(35'h1ff, 3'd7, 1'b1);
        check("full_no_ack", rd_ack, 0);
        tick();
        check("full_still_no_ack", rd_ack, 0);
        check("full_cnt_hold", rd_q_cnt, 8);
        do_pop();
        check("full_late_ack", rd_ack, 1);
        check("full_cnt_same", rd_q_cnt, 8);
        check("full_next_head", cmd_addr, 35'h101);
        check("full_next_id", cmd_id, 1);
        cmd_pop = 1'b1;
        for (int k = 2; k <= 8; k++) begin
            tick();
            check($sformatf("b2b_addr%0d", k), cmd_addr, (k == 8) ? 35'h1ff : 35'h100 + 35'(k));
            check($sformatf("b2b_dummy%0d", k), cmd_dummy, (k == 5 || k == 8) ? 1 : 0);
        end
        cmd_pop = 1'b0;
        check("b2b_last_id", cmd_id, 7);
        check("b2b_last_cnt", rd_q_cnt, 1);
        do_pop();
        check("drain_vld", cmd_vld, 0);
        check("drain_cnt", rd_q_cnt, 0);
        check("drain_no_err", proto_err, 0);

        // Watermark: 7 writes + 1 read; writes win while occupancy stays >= 6
        for (int i = 0; i < 7; i++) send_wr(35'h400 + 35'(i * 2));
        send_rd(35'h7_0000_0040, 3'd5, 1'b0);
        check("wm_wr_cnt7", wr_q_cnt, 7);
        check("wm_rd_cnt1", rd_q_cnt, 1);
        check("wm_sel0", cmd_is_wr, 1);
        check("wm_addr0", cmd_addr, 35'h400);
        do_pop();
        check("wm_wr_cnt6", wr_q_cnt, 6);
        check("wm_sel1", cmd_is_wr, 1);
        check("wm_addr1", cmd_addr, 35'h402);
        do_pop();
        check("wm_wr_cnt5", wr_q_cnt, 5);
        check("wm_sel_rd", cmd_is_wr, 0);
        check("wm_rd_addr", cmd_addr, 35'h7_0000_0040);
        check("wm_rd_id", cmd_id, 5);
        do_pop();
        check("wm_back_wr", cmd_is_wr, 1);
        check("wm_addr2", cmd_addr, 35'h404);
        cmd_pop = 1'b1;
        repeat (5) tick();
        cmd_pop = 1'b0;
        check("wm_drain_cnt", wr_q_cnt, 0);
        check("wm_drain_vld", cmd_vld, 0);
        check("wm_no_err", proto_err, 0);

        // rd+wr collision: read taken, write dropped, sticky error
        rd_req = 1'b1; wr_req = 1'b1; addr = 35'h3_0000_00a0; rd_id = 3'd2;
        tick();
        rd_req = 1'b0; wr_req = 1'b0;
        check("col_rd_ack", rd_ack, 1);
        check("col_no_wr_ack", wr_ack, 0);
        check("col_err", proto_err, 1);
        check("col_rd_cnt", rd_q_cnt, 1);
        check("col_wr_cnt", wr_q_cnt, 0);
        tick();
        check("col_no_late_wr_ack", wr_ack, 0);
        do_pop();
        check("col_err_sticky", proto_err, 1);
        rst_l = 1'b0;
        tick();
        rst_l = 1'b1;
        check("col_err_cleared", proto_err, 0);
        tick();
        check("col_err_stays_clear", proto_err, 0);

        // Reset with 3 reads queued and a write held
        for (int i = 0; i < 3; i++) send_rd(35'h50 + 35'(i), 3'(i), 1'b0);
        for (int i = 0; i < 9; i++) send_wr(35'h800 + 35'(i * 2));
        check("rq_held_no_ack", wr_ack, 0);
        check("rq_wr_cnt", wr_q_cnt, 8);
        check("rq_rd_cnt", rd_q_cnt, 3);
        rst_l = 1'b0;
        tick();
        check("rq_rst_rd_cnt", rd_q_cnt, 0);
        check("rq_rst_wr_cnt", wr_q_cnt, 0);
        check("rq_rst_vld", cmd_vld, 0);
        check("rq_rst_acks", {rd_ack, wr_ack}, 0);
        rst_l = 1'b1;
        tick();
        check("rq_post_no_ack", wr_ack, 0);
        check("rq_post_wr_cnt", wr_q_cnt, 0);
        check("rq_post_vld", cmd_vld, 0);

        // Pop with nothing presented is a protocol error
        do_pop();
        check("pop_empty_err", proto_err, 1);
        check("pop_empty_cnt", rd_q_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dram_sctag_req_rcv.md
Name: dram_sctag_req_rcv

Overview:
DRAM-controller-side receiver for the sctag→DRAM request interface. It captures sctag read requests (35-bit address [39:5], 3-bit ID, dummy flag) and write requests (34-bit address [39:6]) and buffers each class in its own queue. It returns one-cycle read/write acks to sctag and presents a single arbitrated command to the DRAM scheduler, with write-drain on a watermark.

Parameters:
RD_DEPTH, 8, read queue entries (power of 2, ≥2)
WR_DEPTH, 8, write queue entries (power of 2, ≥2)
WR_HI_WM, 6, write-queue occupancy at or above which writes win arbitration

Ports:
rclk  in  1  clock
rst_l  in  1  synchronous active-low reset
sctag_dram_rd_req  in  1  one-cycle read request pulse
sctag_dram_rd_dummy_req  in  1  read is dummy (no data return); qualified by rd_req
sctag_dram_rd_req_id  in  3  read tag
sctag_dram_wr_req  in  1  one-cycle write request pulse
sctag_dram_addr  in  35  address [39:5]; sampled with either req
dram_sctag_rd_ack  out  1  read accepted into queue
dram_sctag_wr_ack  out  1  write accepted into queue
cmd_vld  out  1  command available to scheduler
cmd_is_wr  out  1  1 = write command, 0 = read command
cmd_addr  out  35  command address [39:5]
cmd_id  out  3  read ID (0 for writes)
cmd_dummy  out  1  dummy read (0 for writes)
cmd_pop  in  1  scheduler consumes the current command
rd_q_cnt  out  log2(RD_DEPTH)+1  read occupancy
wr_q_cnt  out  log2(WR_DEPTH)+1  write occupancy
proto_err  out  1  sticky protocol-violation flag

Behaviour:
- One clock (rclk). Synchronous active-low reset (rst_l). Reset clears queues, holding registers, acks, cmd_vld, proto_err, and counts to 0.
- Protocol: sctag keeps at most one unacked read and one unacked write outstanding. rd_req and wr_req are never asserted in the same cycle, because they share the address bus.
- Holding stage: each class has a one-entry holding register.
  - The holding register loads on req.
  - It transfers to its queue in the first cycle it is valid and the queue is not full. The transfer may be the same cycle it loaded.
  - The ack is registered and pulses exactly one cycle after the transfer.
  - Minimum request→ack latency is 1 cycle. With the queue full, the ack is delayed until a pop frees an entry.
- Write address: bit 5 is forced to 0 when stored. Writes are 64B aligned.
- Protocol errors: proto_err sets if any of the following occurs:
  - rd_req and wr_req are asserted together;
  - a req arrives while that class's holding register is still valid;
  - cmd_pop is asserted while cmd_vld=0.
  - On a rd+wr collision, the read is taken and the write is dropped.
  - proto_err clears only on reset.
- Arbitration: a registered selector, evaluated when no command is presented or on cmd_pop.
  - If wr_q_cnt ≥ WR_HI_WM, select write.
  - Else if the read queue is non-empty, select read.
  - Else if the write queue is non-empty, select write.
- Command port: cmd_* reflect the selected queue head combinationally from a registered select.
  - cmd_vld = selected queue non-empty.
  - On cmd_pop the head is dequeued and the next select takes effect the following cycle.
  - Back-to-back pops are allowed every cycle.
- Simultaneous push and pop on the same queue keeps the count unchanged. A full queue with a pop accepts the held entry in the same cycle.
- Pointers wrap modulo depth. Counts saturate at depth; overflow is prevented by the holding stage.

Optional Feature:
DRAM_REQ_ADDR_PAR_EN:
- Defined:
  - Adds input sctag_dram_addr_par (1, even parity over the 35 address bits).
  - Parity is checked at holding-register load.
  - On mismatch, the request is still acked but flagged; it is enqueued with a poison bit.
  - A poisoned read is presented with cmd_dummy=1; a poisoned write is dropped at pop with no DRAM effect.
  - A sticky addr_par_err output (1) is added.
- Undefined: no parity port, no poison bit, no addr_par_err.

Decomposition:
- Package dram_req_pkg: address width (35), ID width (3), and the read/write queue entry struct types (addr, id, dummy, poison).
- Sub-module dram_req_fifo: parameterized synchronous FIFO (depth, entry type) with push/pop/full/empty/count. Instantiated twice.

Test Plan:
- Single read, addr=35'h1_2345_6789, id=3 → rd_ack 1 cycle after req; cmd_vld, cmd_is_wr=0, cmd_addr=35'h1_2345_6789, cmd_id=3; pop → cmd_vld=0, rd_q_cnt=0.
- Write with addr bit5=1 (35'h0_0000_0021) → wr_ack after 1 cycle; cmd_addr=35'h0_0000_0020, cmd_is_wr=1.
- 8 reads with cmd_pop held 0 → rd_q_cnt=8; 9th read gets no ack; pop once → 9th ack appears the cycle after the pop.
- 6 writes then 1 read queued → writes are presented first until wr_q_cnt=5, then the read is presented.
- rd_req and wr_req asserted in the same cycle → proto_err=1, only rd_ack returns; proto_err holds until rst_l=0 for one cycle.
- Reset asserted with 3 reads queued and a write held → next cycle all counts 0, cmd_vld=0, no acks issued.
